branch_resolve_unit: RTL

//  Resolves conditional branches in EX for the pipelined core: all six RV64I compare modes, mispredict detection

---
 rtl/branch_resolve_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Resolves conditional branches in EX. It evaluates the six RV64I compare modes and
//   checks the outcome against the prediction carried down the pipe. On a mispredict
//   it raises a registered flush/redirect to IF/ID. It also owns a 2-bit
//   saturating-counter BHT that is read combinationally by IF, and keeps saturating
//   counts of resolved and mispredicted branches.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   if_pc               IF-stage PC for the prediction lookup
//   if_pred_taken       MSB of the BHT entry selected by if_pc (combinational)
//   ex_valid            EX-stage instruction valid
//   ex_is_branch        EX instruction is a conditional branch
//   funct3              branch compare mode
//   rs1_data, rs2_data  forwarded compare operands
//   ex_pc, ex_imm       EX PC and sign-extended branch offset
//   ex_pred_taken       prediction carried with the instruction
//   ex_pred_target      predicted target carried with the instruction
//   flush_o             one-cycle pulse that kills younger IF/ID/EX instructions
//   redirect_pc_o       correct next PC; meaningful only while flush_o is high
//   illegal_o           one-cycle pulse for a branch with a reserved funct3
//   branch_cnt_o        legal resolved branches since reset (saturating)
//   mispred_cnt_o       mispredicted branches since reset (saturating)
module branch_resolve_unit #(
  parameter int XLEN        = 64,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             flush_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  logic             flush_q, flush_d;
  logic             illegal_q, illegal_d;
  logic [XLEN-1:0]  redirect_q, redirect_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic             resolve;
  logic             legal;
  logic             do_update;
  logic             taken;
  logic             mispredict;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  fallthru;
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] look_idx;

  // The EX slot is wrong-path while our own flush is out, so it is ignored then.
  assign resolve   = ex_valid & ex_is_branch & ~flush_q;
  assign legal     = (funct3[2:1] != 2'b01);
  assign do_update = resolve & legal;

  assign target   = ex_pc + ex_imm;
  assign fallthru = ex_pc + XLEN'(4);
  assign upd_idx  = ex_pc[IDX_W+1:2];
  assign look_idx = if_pc[IDX_W+1:2];

  always_comb begin
    taken = 1'b0;
    unique case (funct3)
      3'b000:  taken = (rs1_data == rs2_data);
      3'b001:  taken = (rs1_data != rs2_data);
      3'b100:  taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  taken = (rs1_data <  rs2_data);
      3'b111:  taken = (rs1_data >= rs2_data);
      default: taken = 1'b0;
    endcase
  end

  // A taken/taken pair with a stale target still sends IF down the wrong path.
  assign mispredict = (taken != ex_pred_taken) |
                      (taken & ex_pred_taken & (ex_pred_target != target));

  always_comb begin
    flush_d       = do_update & mispredict;
    illegal_d     = resolve & ~legal;
    redirect_d    = redirect_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (flush_d) begin
      redirect_d = taken ? target : fallthru;
    end
    if (do_update && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (flush_d && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  // Per-entry next state: only the entry addressed by the resolving branch moves,
  // and it saturates at 2'b11 / 2'b00.
  for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht_next
    always_comb begin
      bht_d[gi] = bht_q[gi];
      if (do_update && (upd_idx == IDX_W'(gi))) begin
        if (taken && (bht_q[gi] != 2'b11)) begin
          bht_d[gi] = bht_q[gi] + 2'd1;
        end else if (!taken && (bht_q[gi] != 2'b00)) begin
          bht_d[gi] = bht_q[gi] - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
      flush_q       <= 1'b0;
      illegal_q     <= 1'b0;
      redirect_q    <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= bht_d[i];
      end
      flush_q       <= flush_d;
      illegal_q     <= illegal_d;
      redirect_q    <= redirect_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // The lookup reads the registered table, so a same-index update in this cycle is
  // not yet visible to IF.
  assign if_pred_taken = bht_q[look_idx][1];
  assign flush_o       = flush_q;
  assign illegal_o     = illegal_q;
  assign redirect_pc_o = redirect_q;
  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule
